money_bag_array: RTL

- Parametrised successor to the single money-bag object. Manages NUM_BAGS independent bags in the playfield.
- Per bag: poll the cell below, wobble, fall row by row, land, and break into gold after a long drop.
- All bags share one request/ACK/NACK port to the map arbiter, granted round-robin. Bags are loaded and cleared by the game controller through wr/data_in.

---
 rtl/money_bag_pkg.sv | 33 +++
 rtl/money_bag_if.sv | 15 +
 rtl/money_bag_slot.sv | 133 +++++++++++++
 rtl/money_bag_array.sv | 116 +++++++++++
 4 files changed

// File: rtl/money_bag_pkg.sv
// Shared definitions for the money-bag array: slot state encoding, request
// kinds, status nibble layout and load-word field positions.
package money_bag_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY  = 3'd0,
    ST_REST   = 3'd1,
    ST_PROBE  = 3'd2,
    ST_WOBBLE = 3'd3,
    ST_FALL   = 3'd4,
    ST_GOLD   = 3'd5
  } slot_state_e;

  // Request kinds carried on req_type
  localparam logic REQ_PROBE = 1'b0;
  localparam logic REQ_MOVE  = 1'b1;

  // Status nibble per slot: {state[2:0], pending}
  localparam int STATUS_W         = 4;
  localparam int STATUS_PEND_BIT  = 0;
  localparam int STATUS_STATE_LSB = 1;

  // Rows fallen counter width (saturating)
  localparam int FALL_CNT_W = 4;

  // Load word: [DATA_W-1]=enable, [POS_W +: IDX_W]=slot, [POS_W-1:0]=position
  localparam int LD_POS_LSB = 0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/money_bag_if.sv
// Request/response link between the bag array and the map arbiter.
interface money_bag_if #(
  parameter int POS_W = 8,
  parameter int IDX_W = 2
);
  logic             req;
  logic             req_type;
  logic [POS_W-1:0] req_content;
  logic [IDX_W-1:0] req_id;
  logic             ACK;
  logic             NACK;

  modport master (output req, req_type, req_content, req_id, input ACK, NACK);
  modport slave  (input req, req_type, req_content, req_id, output ACK, NACK);
endinterface

// File: rtl/money_bag_slot.sv
// One bag slot: position, rows-fallen count, shared wobble/poll timer and
// the behaviour FSM. Tells the arbiter when it needs a probe or a move.
module money_bag_slot
  import money_bag_pkg::*;
#(
  parameter int POS_W      = 8,
  parameter int COLS       = 16,
  parameter int ROWS       = 16,
  parameter int WOBBLE_CYC = 8,
  parameter int POLL_CYC   = 16,
  parameter int BREAK_ROWS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             load_en,
  input  logic [POS_W-1:0] load_pos,
  input  logic             ack,
  input  logic             nack,
  output logic             need_req,
  output logic             req_type,
  output logic [POS_W-1:0] pos,
  output slot_state_e      state
);

  localparam int TMR_MAX = (WOBBLE_CYC > POLL_CYC) ? WOBBLE_CYC : POLL_CYC;
  localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;
  localparam logic [TMR_W-1:0]      WOBBLE_T    = TMR_W'(WOBBLE_CYC);
  localparam logic [TMR_W-1:0]      POLL_T      = TMR_W'(POLL_CYC);
  localparam logic [TMR_W-1:0]      TMR_ONE     = TMR_W'(1);
  localparam logic [POS_W-1:0]      BOTTOM_BASE = POS_W'((ROWS - 1) * COLS);
  localparam logic [POS_W-1:0]      COLS_P      = POS_W'(COLS);
  localparam logic [FALL_CNT_W-1:0] BREAK_P     = FALL_CNT_W'(BREAK_ROWS);
  localparam logic [FALL_CNT_W-1:0] CNT_ONE     = FALL_CNT_W'(1);

  slot_state_e           state_nx;
  logic [POS_W-1:0]      pos_nx;
  logic [FALL_CNT_W-1:0] fall_cnt, fall_cnt_nx;
  logic [TMR_W-1:0]      tmr, tmr_nx;
  logic                  fall_move, fall_move_nx;
  logic                  active, bottom, miss, hit;

  assign active   = (state == ST_PROBE) || (state == ST_FALL);
  assign bottom   = (pos >= BOTTOM_BASE);
  // Nothing lies below the bottom row, so it behaves as a refused probe
  assign miss     = nack || (active && bottom);
  assign hit      = ack && !miss;
  assign need_req = active && !bottom;
  assign req_type = (state == ST_FALL) ? fall_move : REQ_PROBE;

  // Next-state: a load overrides everything, otherwise step the slot FSM
  always_comb begin
    state_nx     = state;
    pos_nx       = pos;
    fall_cnt_nx  = fall_cnt;
    tmr_nx       = tmr;
    fall_move_nx = fall_move;
    if (load) begin
      state_nx     = load_en ? ST_PROBE : ST_EMPTY;
      tmr_nx       = '0;
      fall_move_nx = 1'b0;
      if (load_en) begin
        pos_nx      = load_pos;
        fall_cnt_nx = '0;
      end
    end else begin
      case (state)
        ST_REST: begin
          if (tmr == '0) state_nx = ST_PROBE;
          else           tmr_nx   = tmr - TMR_ONE;
        end
        ST_PROBE: begin
          if (miss) begin
            state_nx = ST_REST;
            tmr_nx   = POLL_T;
          end else if (hit) begin
            state_nx = ST_WOBBLE;
            tmr_nx   = WOBBLE_T;
          end
        end
        ST_WOBBLE: begin
          if (tmr == '0) begin
            state_nx     = ST_FALL;
            fall_move_nx = REQ_MOVE;
          end else begin
            tmr_nx = tmr - TMR_ONE;
          end
        end
        ST_FALL: begin
          if (miss) begin
            fall_move_nx = REQ_PROBE;
            if (fall_cnt >= BREAK_P) begin
              state_nx = ST_GOLD;
            end else begin
              state_nx    = ST_REST;
              fall_cnt_nx = '0;
              tmr_nx      = POLL_T;
            end
          end else if (hit) begin
            // A granted move lands the bag one row lower; every further
            // move is preceded by a fresh probe of the new cell below
            if (fall_move) begin
              pos_nx       = pos + COLS_P;
              fall_move_nx = REQ_PROBE;
              if (fall_cnt != '1) fall_cnt_nx = fall_cnt + CNT_ONE;
            end else begin
              fall_move_nx = REQ_MOVE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Slot state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      pos       <= '0;
      fall_cnt  <= '0;
      tmr       <= '0;
      fall_move <= 1'b0;
    end else begin
      state     <= state_nx;
      pos       <= pos_nx;
      fall_cnt  <= fall_cnt_nx;
      tmr       <= tmr_nx;
      fall_move <= fall_move_nx;
    end
  end

endmodule

// File: rtl/money_bag_array.sv
// Array of NUM_BAGS money bags sharing one arbiter port. Decodes controller
// loads, grants requests round-robin, routes responses, packs status.
module money_bag_array
  import money_bag_pkg::*;
#(
  parameter int NUM_BAGS   = 4,
  parameter int DATA_W     = 16,
  parameter int POS_W      = 8,
  parameter int COLS       = 16,
  parameter int ROWS       = 16,
  parameter int WOBBLE_CYC = 8,
  parameter int POLL_CYC   = 16,
  parameter int BREAK_ROWS = 2,
  parameter int IDX_W      = idx_width(NUM_BAGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic [DATA_W-1:0]            data_in,
  money_bag_if.master                  bus,
  output logic [STATUS_W*NUM_BAGS-1:0] status
);

  localparam logic [POS_W-1:0] COLS_P = POS_W'(COLS);

  logic             ld_en, ld_ok, ld_unused;
  logic [IDX_W-1:0] ld_idx;
  logic [POS_W-1:0] ld_pos;

  assign ld_en     = data_in[DATA_W-1];
  assign ld_idx    = data_in[POS_W +: IDX_W];
  assign ld_pos    = data_in[LD_POS_LSB +: POS_W];
  assign ld_ok     = wr && (int'(ld_idx) < NUM_BAGS);
  assign ld_unused = &{1'b0, data_in};

  logic [NUM_BAGS-1:0] slot_load, slot_ack, slot_nack, slot_need, slot_type, slot_pend;
  logic [POS_W-1:0]    slot_pos [NUM_BAGS];
  slot_state_e         slot_state [NUM_BAGS];

  logic             resp, resp_ack, discard, sel_vld;
  logic [IDX_W-1:0] ptr, sel, cand;

  assign resp     = bus.req && (bus.ACK || bus.NACK);
  // Both lines high counts as a refusal
  assign resp_ack = bus.ACK && !bus.NACK;

  for (genvar i = 0; i < NUM_BAGS; i++) begin : g_slot
    assign slot_load[i] = ld_ok && (ld_idx == IDX_W'(i));
    // A slot reloaded mid-request no longer owns it; its answer is dropped
    assign slot_pend[i] = bus.req && !discard && (bus.req_id == IDX_W'(i));
    assign slot_ack[i]  = slot_pend[i] && resp && resp_ack;
    assign slot_nack[i] = slot_pend[i] && resp && !resp_ack;
    assign status[STATUS_W*i +: STATUS_W] = {slot_state[i], slot_pend[i]};

    money_bag_slot #(
      .POS_W      (POS_W),
      .COLS       (COLS),
      .ROWS       (ROWS),
      .WOBBLE_CYC (WOBBLE_CYC),
      .POLL_CYC   (POLL_CYC),
      .BREAK_ROWS (BREAK_ROWS)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (slot_load[i]),
      .load_en  (ld_en),
      .load_pos (ld_pos),
      .ack      (slot_ack[i]),
      .nack     (slot_nack[i]),
      .need_req (slot_need[i]),
      .req_type (slot_type[i]),
      .pos      (slot_pos[i]),
      .state    (slot_state[i])
    );
  end

  // Round-robin search starting one past the last granted slot
  always_comb begin
    sel     = ptr;
    sel_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_BAGS; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_BAGS);
      if (!sel_vld && slot_need[cand]) begin
        sel_vld = 1'b1;
        sel     = cand;
      end
    end
  end

  // Request register: hold until answered, then grant the next slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.req         <= 1'b0;
      bus.req_type    <= 1'b0;
      bus.req_content <= '0;
      bus.req_id      <= '0;
      ptr             <= '0;
      discard         <= 1'b0;
    end else if (bus.req) begin
      if (resp) begin
        bus.req <= 1'b0;
        discard <= 1'b0;
      end else if (slot_load[bus.req_id]) begin
        discard <= 1'b1;
      end
    end else if (sel_vld) begin
      bus.req         <= 1'b1;
      bus.req_type    <= slot_type[sel];
      bus.req_content <= slot_pos[sel] + COLS_P;
      bus.req_id      <= sel;
      ptr             <= sel;
    end
  end

endmodule
